uart_char_rx: RTL and testbench
===============================

# uart_char_rx

Serial character source for the text display path. Receives 8-bit characters on a UART line (8N1, LSB first, 16x oversampled), validates framing, and presents each good character on `cout` with a single-cycle `we` strobe. The strobe and data connect directly to the display controller's `cin`/`we` character input, so the block is the writer that feeds the character pane.

## Interface
Parameters:
- `CLK_FREQ`, 100_000_000: system clock frequency in Hz.
- `BAUD`, 9600: line rate in bit/s.
- Derived: `DIV = CLK_FREQ/(BAUD*16)`, integer truncation. Default gives 651. A bit period is `16*DIV` clk, which is 10416 by default.

Ports:
- `clk`, input, 1: system clock. All logic runs on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `rx`, input, 1: asynchronous serial line. Idle level is high.
- `cout`, output, 8: last accepted character. Held until the next accepted character.
- `we`, output, 1: one-clk pulse when `cout` carries a new character.
- `frame_err`, output, 1: one-clk pulse on a rejected frame.
- `busy`, output, 1: high while the FSM is not in IDLE.

## Operation
- Input conditioning: `rx` passes through a 2-FF synchronizer to give `rx_s`. The synchronizer FFs reset to 1.
- Tick generator: counter runs 0..DIV-1 and emits `tick` on reaching DIV-1. The counter is forced to 0 in IDLE, so sample phase aligns to the start edge.
- Oversample counter: `os_cnt` is 4 bits, advances on each `tick`, and wraps from 15 to 0.
- FSM states: IDLE, START, DATA, PARITY (present only with the macro), STOP.
  - IDLE: `rx_s==0` moves to START with `os_cnt` set to 0.
  - START: at `os_cnt==7` (mid start bit), `rx_s==0` moves to DATA with `os_cnt` set to 0 and bit index set to 0. `rx_s==1` is a glitch and returns to IDLE with no pulses.
  - DATA: at `os_cnt==15`, `rx_s` shifts into `shreg[7]` with right shift, so the first bit received lands in `shreg[0]` after 8 samples. The FSM leaves DATA after the 8th sample (index 7).
  - PARITY: at `os_cnt==15`, the sampled bit is compared against even parity of `shreg`, and `par_bad` is latched on mismatch.
  - STOP: at `os_cnt==15`:
    - `rx_s==1` and no `par_bad`: `cout` loads `shreg` and `we` pulses.
    - Otherwise `frame_err` pulses and `cout` is unchanged.
    - Either way the next state is IDLE.
- Returning to IDLE at mid stop bit allows back-to-back frames with exactly one stop bit.
- If `rx_s` is still low in IDLE after a bad stop bit, it is treated as a new start edge. This is the break/garbage case; the START check rejects it if the line stays low only briefly.
- Reset values: `cout=8'h00`, `we=0`, `frame_err=0`, `busy=0`, FSM in IDLE, all counters 0, `shreg=0`, `par_bad=0`.
- `reset` asserted mid-frame aborts the frame on the next edge. No `we` or `frame_err` pulse is emitted for it.
- `we` and `frame_err` are never high in the same cycle.

## Timing
- Synchronizer latency: 2 clk from an `rx` change to the matching `rx_s` change.
- Start-to-sample: first data sample at `8*DIV + 16*DIV` clk after IDLE sees the `rx_s` fall, within ±1 clk.
- `we` latency: `we` is registered and goes high the clk after the stop-bit sample `tick`. `cout` changes on that same edge.
- `busy` rises 1 clk after the start edge is seen in `rx_s`. It falls on the same edge as the `we` or `frame_err` pulse.
- Sustained throughput: one character per 10 bit periods, or 11 with parity.
- Baud tolerance: ±2% combined mismatch must still decode correctly.

## Configuration
- `UART_PARITY_EN`:
  - Defined: frames are 8E1. The PARITY state is compiled in, and a parity mismatch gives `frame_err` instead of `we`.
  - Undefined: frames are 8N1. The PARITY state and `par_bad` are absent, and the stop bit follows the 8th data bit directly.

## Test plan
All cases use the default parameters (bit period 10416 clk).
- Good frame: send 8N1 `0x41` after reset. Expect exactly one `we` pulse with `cout==8'h41`, `frame_err` never high, and `busy` low afterwards.
- Back-to-back frames: send `0x48` then `0x69`, one stop bit each, no idle gap. Expect two `we` pulses about 104160 clk apart, with `cout` equal to `8'h48` then `8'h69`.
- Start glitch: drive `rx` low for 3000 clk, then high. Expect no `we`, no `frame_err`, and `busy` back low before 8*651+4 clk after the fall.
- Bad stop bit: send `0x55` with stop bit 0 after a prior good `0x41`. Expect one `frame_err` pulse, no `we`, and `cout` still `8'h41`.
- Reset mid-frame: assert `reset` for 1 clk during data bit 4 of `0x7E`. Expect on the next edge `busy=0`, `cout=8'h00`, and no pulse for that frame. A following `0x31` decodes normally.
- Parity (`UART_PARITY_EN` defined): send `0x41` with parity bit 1. Expect a `frame_err` pulse. Resend with parity bit 0 and expect `we` with `cout==8'h41`.

Source files
------------

// File: rtl/uart_char_rx.sv
// UART character receiver (8N1, LSB first, 16x oversampled) feeding the display cin/we input.
// Define UART_PARITY_EN to receive 8E1 frames with even-parity checking.
module uart_char_rx #(
    parameter int unsigned CLK_FREQ = 100_000_000,
    parameter int unsigned BAUD     = 9600
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] cout,
    output logic       we,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned DIV   = CLK_FREQ / (BAUD * 16);
    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned OS_W  = 4;
    localparam int unsigned IDX_W = 3;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t             state, state_n;
    logic [DIV_W-1:0]   div_cnt, div_cnt_n;
    logic [OS_W-1:0]    os_cnt, os_cnt_n;
    logic [IDX_W-1:0]   bit_idx, bit_idx_n;
    logic [7:0]         shreg, shreg_n;
    logic [7:0]         cout_n;
    logic               we_n, frame_err_n, busy_n;
    logic               rx_meta, rx_s;
    logic               tick_c, stop_ok_c;
`ifdef UART_PARITY_EN
    logic               par_bad, par_bad_n;
`endif

    // Two-flop synchronizer; resets to the idle line level
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    assign tick_c = (div_cnt == DIV_W'(DIV - 1));

`ifdef UART_PARITY_EN
    assign stop_ok_c = rx_s & ~par_bad;
`else
    assign stop_ok_c = rx_s;
`endif

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            div_cnt   <= '0;
            os_cnt    <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            cout      <= 8'h00;
            we        <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
`ifdef UART_PARITY_EN
            par_bad   <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            div_cnt   <= div_cnt_n;
            os_cnt    <= os_cnt_n;
            bit_idx   <= bit_idx_n;
            shreg     <= shreg_n;
            cout      <= cout_n;
            we        <= we_n;
            frame_err <= frame_err_n;
            busy      <= busy_n;
`ifdef UART_PARITY_EN
            par_bad   <= par_bad_n;
`endif
        end
    end

    // Next-state, counters and output strobes
    always_comb begin
        state_n     = state;
        div_cnt_n   = div_cnt;
        os_cnt_n    = os_cnt;
        bit_idx_n   = bit_idx;
        shreg_n     = shreg;
        cout_n      = cout;
        we_n        = 1'b0;
        frame_err_n = 1'b0;
`ifdef UART_PARITY_EN
        par_bad_n   = par_bad;
`endif

        // Divider held at zero in IDLE so sampling phase is set by the start edge
        if (state == IDLE) begin
            div_cnt_n = '0;
        end else if (tick_c) begin
            div_cnt_n = '0;
        end else begin
            div_cnt_n = div_cnt + DIV_W'(1);
        end

        if (tick_c) begin
            os_cnt_n = os_cnt + OS_W'(1);
        end

        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_n  = START;
                    os_cnt_n = '0;
`ifdef UART_PARITY_EN
                    par_bad_n = 1'b0;
`endif
                end
            end
            START: begin
                if (tick_c && os_cnt == OS_W'(7)) begin
                    if (!rx_s) begin
                        state_n   = DATA;
                        os_cnt_n  = '0;
                        bit_idx_n = '0;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            DATA: begin
                if (tick_c && os_cnt == OS_W'(15)) begin
                    shreg_n   = {rx_s, shreg[7:1]};
                    bit_idx_n = bit_idx + IDX_W'(1);
                    if (bit_idx == IDX_W'(7)) begin
`ifdef UART_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end
                end
            end
`ifdef UART_PARITY_EN
            PARITY: begin
                if (tick_c && os_cnt == OS_W'(15)) begin
                    if (rx_s != ^shreg) begin
                        par_bad_n = 1'b1;
                    end
                    state_n = STOP;
                end
            end
`endif
            STOP: begin
                // Return at mid stop bit so a following start edge is not missed
                if (tick_c && os_cnt == OS_W'(15)) begin
                    if (stop_ok_c) begin
                        cout_n = shreg;
                        we_n   = 1'b1;
                    end else begin
                        frame_err_n = 1'b1;
                    end
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        busy_n = (state_n != IDLE);
    end

endmodule

// File: tb/tb_uart_char_rx.sv
// Directed bench for uart_char_rx; runs with a small divider (DIV=4, 64 clk per bit).
module tb_uart_char_rx;

    localparam int unsigned CLK_FREQ = 1_600_000;
    localparam int unsigned BAUD     = 25_000;
    localparam int unsigned BIT      = 64;
`ifdef UART_PARITY_EN
    localparam int unsigned FRAME    = BIT * 11;
`else
    localparam int unsigned FRAME    = BIT * 10;
`endif

    logic       clk;
    logic       reset;
    logic       rx;
    logic [7:0] cout;
    logic       we;
    logic       frame_err;
    logic       busy;

    int errors;
    int checks;
    int cyc;
    int we_cnt;
    int ferr_cnt;
    int both_cnt;
    int we_cyc;
    int we_cyc_prev;
    logic [7:0] we_val;
    logic [7:0] we_val_prev;
    int we0;
    int fe0;

    uart_char_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .cout      (cout),
        .we        (we),
        .frame_err (frame_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor sampled on the falling edge
    always @(negedge clk) begin
        if (we) begin
            we_cnt      <= we_cnt + 1;
            we_cyc_prev <= we_cyc;
            we_cyc      <= cyc;
            we_val_prev <= we_val;
            we_val      <= cout;
        end
        if (frame_err) ferr_cnt <= ferr_cnt + 1;
        if (we && frame_err) both_cnt <= both_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Sends one frame; abort_bit >= 0 pulses reset halfway through that bit and ends the frame
    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_flip,
                              input int abort_bit);
        logic [10:0] bits;
        int nb;
        bits = '1;
        bits[0] = 1'b0;
        bits[8:1] = d;
`ifdef UART_PARITY_EN
        bits[9]  = (^d) ^ par_flip;
        bits[10] = stop_b;
        nb = 11;
`else
        bits[9] = stop_b;
        nb = 10;
        if (par_flip) nb = 10;
`endif
        for (int i = 0; i < nb; i++) begin
            rx = bits[i];
            if (i == abort_bit) begin
                idle(BIT / 2);
                reset = 1'b1;
                idle(1);
                reset = 1'b0;
                check("abort_busy", 32'(busy), 32'd0);
                check("abort_cout", 32'(cout), 32'h00);
                rx = 1'b1;
                return;
            end
            idle(BIT);
        end
        rx = 1'b1;
    endtask

    initial begin
        errors = 0; checks = 0; cyc = 0;
        we_cnt = 0; ferr_cnt = 0; both_cnt = 0;
        we_cyc = 0; we_cyc_prev = 0; we_val = 8'h00; we_val_prev = 8'h00;
        reset = 1'b1;
        rx = 1'b1;
        idle(3);
        reset = 1'b0;
        check("rst_cout", 32'(cout), 32'h00);
        check("rst_we", 32'(we), 32'd0);
        check("rst_ferr", 32'(frame_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        // Good frame
        idle(10);
        send_frame(8'h41, 1'b1, 1'b0, -1);
        idle(BIT);
        check("good_we_cnt", 32'(we_cnt), 32'd1);
        check("good_ferr_cnt", 32'(ferr_cnt), 32'd0);
        check("good_val", 32'(we_val), 32'h41);
        check("good_busy", 32'(busy), 32'd0);

        // Back-to-back frames, single stop bit, no gap
        we0 = we_cnt;
        send_frame(8'h48, 1'b1, 1'b0, -1);
        send_frame(8'h69, 1'b1, 1'b0, -1);
        idle(BIT);
        check("b2b_we_cnt", 32'(we_cnt - we0), 32'd2);
        check("b2b_first", 32'(we_val_prev), 32'h48);
        check("b2b_second", 32'(we_val), 32'h69);
        check("b2b_spacing", 32'(we_cyc - we_cyc_prev), 32'(FRAME));
        check("b2b_cout", 32'(cout), 32'h69);

        // Start glitch shorter than half a bit
        we0 = we_cnt; fe0 = ferr_cnt;
        rx = 1'b0;
        idle(18);
        check("glitch_busy_hi", 32'(busy), 32'd1);
        rx = 1'b1;
        idle(18);
        check("glitch_busy_lo", 32'(busy), 32'd0);
        idle(2 * BIT);
        check("glitch_we", 32'(we_cnt - we0), 32'd0);
        check("glitch_ferr", 32'(ferr_cnt - fe0), 32'd0);

        // Bad stop bit after a good 0x41
        send_frame(8'h41, 1'b1, 1'b0, -1);
        idle(BIT);
        we0 = we_cnt; fe0 = ferr_cnt;
        send_frame(8'h55, 1'b0, 1'b0, -1);
        idle(2 * BIT);
        check("stop_ferr", 32'(ferr_cnt - fe0), 32'd1);
        check("stop_we", 32'(we_cnt - we0), 32'd0);
        check("stop_cout", 32'(cout), 32'h41);
        check("stop_busy", 32'(busy), 32'd0);

        // Reset during data bit 4, then a normal frame
        we0 = we_cnt; fe0 = ferr_cnt;
        send_frame(8'h7E, 1'b1, 1'b0, 5);
        idle(2 * BIT);
        check("abort_we", 32'(we_cnt - we0), 32'd0);
        check("abort_ferr", 32'(ferr_cnt - fe0), 32'd0);
        send_frame(8'h31, 1'b1, 1'b0, -1);
        idle(BIT);
        check("after_we", 32'(we_cnt - we0), 32'd1);
        check("after_cout", 32'(cout), 32'h31);
        check("after_ferr", 32'(ferr_cnt - fe0), 32'd0);

`ifdef UART_PARITY_EN
        // 0x41 has even parity 0: flipped parity must be rejected
        we0 = we_cnt; fe0 = ferr_cnt;
        send_frame(8'h41, 1'b1, 1'b1, -1);
        idle(BIT);
        check("par_bad_ferr", 32'(ferr_cnt - fe0), 32'd1);
        check("par_bad_we", 32'(we_cnt - we0), 32'd0);
        send_frame(8'h41, 1'b1, 1'b0, -1);
        idle(BIT);
        check("par_ok_we", 32'(we_cnt - we0), 32'd1);
        check("par_ok_cout", 32'(cout), 32'h41);
`endif

        check("we_ferr_overlap", 32'(both_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
